posit_decode_stage: RTL and testbench
=====================================

# posit_decode_stage

Pipelined posit operand decoder that sits directly upstream of `Posit_Multiplier`. It accepts packed posits over a valid/ready handshake and unpacks each one into sign, zero/NaR flags, a combined scale (regime·2^ES + exponent) and a hidden-bit-normalised fraction. The multiplier core consumes these fields, so regime and exponent extraction happens once per operand and is registered off the multiply path.

## Interface
Parameters:
- `N`, 32: posit width.
- `ES`, 4: exponent field width.
- `SW`, `$clog2(N)+ES+1` (10): signed scale width. Derived; do not override.
- `FW`, `N-ES-2` (26): fraction width. Includes the hidden bit at [FW-1]. Derived.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_posit` is valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_posit`  in  N  packed posit, two's-complement encoding.
- `out_valid`  out  1  decoded fields valid.
- `out_ready`  in  1  downstream accepts.
- `out_sign`  out  1  sign bit.
- `out_zero`  out  1  input was 0.
- `out_nar`  out  1  input was NaR (1 followed by all zeros).
- `out_scale`  out  SW  signed scale, k·2^ES + e.
- `out_frac`  out  FW  {1'b1, fraction bits left-aligned, zero-padded}.

## Operation
- Transfer occurs when a port's valid and ready are both high. Transfers complete in order, with no loss and no duplication.
- Special values:
  - `in_posit==0` gives zero=1.
  - `in_posit=={1,0…}` gives nar=1.
  - In both cases sign, scale and frac are 0.
- All other values:
  - sign = x[N-1]; a = sign ? -x : x.
  - Regime is the run of bits equal to a[N-2], with run length m. If a[N-2]=1 then k=m-1, else k=-m.
  - Skip the terminating bit, if present.
  - The next ES bits form e. Any bits truncated past the LSB are treated as zeros, placed MSB-first.
  - The remaining bits form the fraction, left-aligned under the hidden 1.
- Scale range is ±(N-2)·2^ES, which is ±480 at the defaults. It always fits SW.
- Stage 1 registers: flags, sign, a, and the run length m.
- Stage 2 registers: k, e, the shifted fraction, and the final fields.

## Timing
- Latency is 2 cycles from input transfer to `out_valid`, provided `out_ready` was high.
- Throughput is 1 per cycle when `out_ready` stays high.
- Per-stage enable: en2 = !v2 | out_ready; en1 = !v1 | en2.
- `in_ready` = en1. It is combinational from the stage valids and `out_ready`; there is no path from `in_valid`.
- Backpressure: at most 2 items are in flight. With `out_ready` low, the stage accepts 2 items, then `in_ready`=0 until a drain.
- Output fields are held stable while `out_valid` & !`out_ready`.
- Reset: v1=v2=0, `out_valid`=0, all data registers 0, and `in_ready`=1 from the first cycle after reset.
- Reset mid-stream discards every in-flight item.
- `in_valid` while `reset` is high is ignored.

## Structure
- Package `posit_pkg` holds:
  - defaults `POSIT_N=32` and `POSIT_ES=4`;
  - the functions `posit_sw(N,ES)` and `posit_fw(N,ES)`;
  - the constant `POSIT_NAR`;
  - the `posit_dec_t` packed struct {sign, zero, nar, scale, frac} at default widths, shared with the multiplier.
- Sub-module `posit_run_count` is combinational. It takes the N-1 bits after the sign and returns the leading-run length m (1..N-1) and the run polarity. It is instantiated in stage 1.

## Test plan
- Stream 0x40000000 (1.0) with `out_ready`=1. Expected after 2 cycles: sign=0, scale=0, frac=26'h2000000.
- Input 0x5C710733 (20000.9). Expected: scale=14, frac=26'h2710733.
- Input 0xC0000000 (-1.0). Expected: sign=1, scale=0, frac=26'h2000000.
  - Then 0x80000000: nar=1, others 0.
  - Then 0x00000000: zero=1, others 0.
- Regime extremes:
  - 0x00000001 gives scale=-480 (10'h220), frac=26'h2000000.
  - 0x7FFFFFFF gives scale=480, frac=26'h2000000.
  - 0x7FFFFFF5 (partial exponent) gives scale=426, frac=26'h2000000.
- Backpressure:
  - Offer A, B, C back-to-back with `out_ready`=0. A and B are accepted; `in_ready` drops; C is held. Output fields stay stable.
  - Raise `out_ready`. Output is A, B, C in order, each exactly once.
- Assert `reset` for 1 cycle with 2 items in flight. Next cycle: `out_valid`=0, `in_ready`=1, and neither item ever appears.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit definitions: default format, derived-width helpers, NaR pattern
// and the decoded-operand record consumed by the multiplier core.
package posit_pkg;

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 4;

    // Signed scale width: enough for +/-(N-2)*2^ES plus the sign.
    function automatic int posit_sw(input int n, input int es);
        return $clog2(n) + es + 1;
    endfunction

    // Fraction width including the hidden bit.
    function automatic int posit_fw(input int n, input int es);
        return n - es - 2;
    endfunction

    localparam int POSIT_SW = posit_sw(POSIT_N, POSIT_ES);
    localparam int POSIT_FW = posit_fw(POSIT_N, POSIT_ES);

    localparam logic [POSIT_N-1:0] POSIT_NAR = {1'b1, {(POSIT_N-1){1'b0}}};

    typedef struct packed {
        logic                sign;
        logic                zero;
        logic                nar;
        logic [POSIT_SW-1:0] scale;
        logic [POSIT_FW-1:0] frac;
    } posit_dec_t;

endpackage

// File: rtl/posit_decode_stage_run_count.sv
// Combinational leading-run detector for the regime field: returns the length
// of the run of bits equal to the MSB, and that MSB as the run polarity.
module posit_run_count #(
    parameter int N = 32
) (
    input  logic [N-2:0]         bits,
    output logic [$clog2(N)-1:0] run_len,
    output logic                 polarity
);
    localparam int RW = $clog2(N);

    logic [N-2:0] diff;

    assign polarity = bits[N-2];
    assign diff     = bits ^ {(N-1){bits[N-2]}};

    // Priority search for the first bit that breaks the run (MSB first).
    always_comb begin
        logic found;
        run_len = RW'(N - 1);
        found   = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!found && diff[i]) begin
                run_len = RW'(N - 2 - i);
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    end

endmodule

// File: rtl/posit_decode_stage.sv
// Two-stage posit operand decoder. Stage 1 captures flags, sign, magnitude
// and regime run length; stage 2 forms k, e, the aligned fraction and scale.
module posit_decode_stage
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES,
    parameter int SW = posit_sw(N, ES),
    parameter int FW = posit_fw(N, ES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_posit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic          out_zero,
    output logic          out_nar,
    output logic [SW-1:0] out_scale,
    output logic [FW-1:0] out_frac
);
    localparam int RW = $clog2(N);

    logic en1, en2;
    logic v1, v2;

    // stage 1 combinational decode of the incoming word
    logic          in_zero, in_nar;
    logic [N-2:0]  in_body;
    logic [RW-1:0] in_run;
    logic          in_pol;

    // stage 1 registers; only the magnitude bits that can follow the shortest
    // regime plus its terminator are kept, the top two are pure regime
    logic          s1_sign, s1_zero, s1_nar, s1_pol;
    logic [N-4:0]  s1_tail;
    logic [RW-1:0] s1_run;

    // stage 2 combinational field extraction
    logic [N-4:0]  tail_shift;
    logic [ES-1:0] exp_s;
    logic [SW-1:0] run_ext, k_s, scale_s;

    assign en2       = !v2 || out_ready;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v2;

    assign in_zero = (in_posit == {N{1'b0}});
    assign in_nar  = (in_posit == {1'b1, {(N-1){1'b0}}});
    // Low N-1 bits of -x depend only on the low N-1 bits of x.
    assign in_body = in_posit[N-1] ? (~in_posit[N-2:0] + {{(N-2){1'b0}}, 1'b1})
                                   : in_posit[N-2:0];

    posit_run_count #(.N(N)) u_run_count (
        .bits     (in_body),
        .run_len  (in_run),
        .polarity (in_pol)
    );

    // Stage 1 capture: advance whenever the stage is empty or stage 2 moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_nar  <= 1'b0;
            s1_pol  <= 1'b0;
            s1_tail <= {(N-3){1'b0}};
            s1_run  <= {RW{1'b0}};
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign <= in_posit[N-1];
                s1_zero <= in_zero;
                s1_nar  <= in_nar;
                s1_pol  <= in_pol;
                s1_tail <= in_body[N-4:0];
                s1_run  <= in_run;
            end
        end
    end

    // Align exponent+fraction to the top by dropping regime and terminator,
    // then combine k and e into the scale.
    always_comb begin
        // tail bit i corresponds to body bit i; shifting by m-1 removes the
        // remaining m+1 regime/terminator bits relative to the full body
        tail_shift = s1_tail << (s1_run - {{(RW-1){1'b0}}, 1'b1});
        exp_s      = tail_shift[N-4 -: ES];
        run_ext    = {{(SW-RW){1'b0}}, s1_run};
        if (s1_pol) begin
            k_s = run_ext - {{(SW-1){1'b0}}, 1'b1};
        end else begin
            k_s = {SW{1'b0}} - run_ext;
        end
        scale_s = (k_s << ES) + {{(SW-ES){1'b0}}, exp_s};
    end

    // Stage 2 output register: holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2        <= 1'b0;
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
            out_nar   <= 1'b0;
            out_scale <= {SW{1'b0}};
            out_frac  <= {FW{1'b0}};
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                out_zero <= s1_zero;
                out_nar  <= s1_nar;
                if (s1_zero || s1_nar) begin
                    out_sign  <= 1'b0;
                    out_scale <= {SW{1'b0}};
                    out_frac  <= {FW{1'b0}};
                end else begin
                    out_sign  <= s1_sign;
                    out_scale <= scale_s;
                    out_frac  <= {1'b1, tail_shift[N-4-ES:0]};
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_decode_stage.sv
// Directed bench for posit_decode_stage: streaming vector table plus
// backpressure and mid-stream reset sequences.
module tb_posit_decode_stage;
    import posit_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_posit;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic        out_zero;
    logic        out_nar;
    logic [9:0]  out_scale;
    logic [25:0] out_frac;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] posit;
        logic        sign;
        logic        zero;
        logic        nar;
        logic [9:0]  scale;
        logic [25:0] frac;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    posit_decode_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_posit  (in_posit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_nar   (out_nar),
        .out_scale (out_scale),
        .out_frac  (out_frac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic posit_dec_t expect_of(input vec_t v);
        posit_dec_t d;
        d.sign  = v.sign;
        d.zero  = v.zero;
        d.nar   = v.nar;
        d.scale = v.scale;
        d.frac  = v.frac;
        return d;
    endfunction

    function automatic posit_dec_t current_out();
        posit_dec_t d;
        d.sign  = out_sign;
        d.zero  = out_zero;
        d.nar   = out_nar;
        d.scale = out_scale;
        d.frac  = out_frac;
        return d;
    endfunction

    initial begin
        posit_dec_t got [3];
        int         n_got;
        logic       c_take;
        logic       ghost;

        //            posit          s     z     n     scale     frac
        vecs[0]  = '{32'h4000_0000, 1'b0, 1'b0, 1'b0, 10'd0,    26'h200_0000};
        vecs[1]  = '{32'h5C71_0733, 1'b0, 1'b0, 1'b0, 10'd14,   26'h271_0733};
        vecs[2]  = '{32'hC000_0000, 1'b1, 1'b0, 1'b0, 10'd0,    26'h200_0000};
        vecs[3]  = '{32'h8000_0000, 1'b0, 1'b0, 1'b1, 10'd0,    26'h000_0000};
        vecs[4]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 10'd0,    26'h000_0000};
        vecs[5]  = '{32'h0000_0001, 1'b0, 1'b0, 1'b0, 10'h220,  26'h200_0000};
        vecs[6]  = '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 10'd480,  26'h200_0000};
        vecs[7]  = '{32'h7FFF_FFF5, 1'b0, 1'b0, 1'b0, 10'd426,  26'h200_0000};
        vecs[8]  = '{32'h2000_0000, 1'b0, 1'b0, 1'b0, 10'h3F0,  26'h200_0000};
        vecs[9]  = '{32'h4800_0001, 1'b0, 1'b0, 1'b0, 10'd4,    26'h200_0001};
        vecs[10] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 10'h220,  26'h200_0000};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_posit  = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        chk("reset_fields",    64'(current_out()), 64'd0);

        // back-to-back stream of the whole table, 2-cycle latency
        for (int c = 0; c < NV + 2; c++) begin
            if (c >= 2) begin
                chk($sformatf("vec%0d_valid", c - 2), 64'(out_valid), 64'd1);
                chk($sformatf("vec%0d_fields", c - 2), 64'(current_out()),
                    64'(expect_of(vecs[c - 2])));
            end
            if (c < NV) begin
                chk($sformatf("vec%0d_in_ready", c), 64'(in_ready), 64'd1);
                in_valid = 1'b1;
                in_posit = vecs[c].posit;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream_idle_valid", 64'(out_valid), 64'd0);

        // backpressure: A, B accepted, C held while out_ready is low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_posit  = vecs[0].posit;
        chk("bp_a_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("bp_b_ready", 64'(in_ready), 64'd1);
        in_posit = vecs[1].posit;
        @(negedge clk);
        in_posit = vecs[2].posit;
        for (int h = 0; h < 3; h++) begin
            chk($sformatf("bp_hold%0d_in_ready", h), 64'(in_ready), 64'd0);
            chk($sformatf("bp_hold%0d_valid", h), 64'(out_valid), 64'd1);
            chk($sformatf("bp_hold%0d_fields", h), 64'(current_out()),
                64'(expect_of(vecs[0])));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_got = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                if (n_got < 3) got[n_got] = current_out();
                n_got++;
            end
            c_take = in_valid && in_ready;
            @(negedge clk);
            if (c_take) in_valid = 1'b0;
        end
        chk("bp_count", 64'(n_got), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_order%0d", i), 64'(got[i]), 64'(expect_of(vecs[i])));
        end

        // reset with two items in flight discards both
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_posit  = vecs[9].posit;
        @(negedge clk);
        in_posit  = vecs[1].posit;
        @(negedge clk);
        chk("rst_full_valid", 64'(out_valid), 64'd1);
        in_posit = vecs[6].posit;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        ghost = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) ghost = 1'b1;
        end
        chk("rst_no_ghost", 64'(ghost), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
